// File: rtl/pipe_pkg.sv
// Shared pipeline types: ALU opcodes, forward-select codes and the EX/MEM record.
package pipe_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_MUL  = 4'b1010
  } alu_op_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] pc_plus4;
    logic [4:0]        rd;
    logic              reg_write;
    logic              mem_write;
    logic [1:0]        result_src;
  } ex_mem_t;

  localparam ex_mem_t EX_MEM_BUBBLE = '0;

endpackage

// File: rtl/alu.sv
// Single-cycle ALU for the EX stage; multiply is handled by the stage itself.
module alu
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_t           op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   y
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt_s;
  assign shamt_s = b[SHW-1:0];

  // Opcode decode; MUL and unused codes yield zero here.
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_SLL:  y = a << shamt_s;
      ALU_SRL:  y = a >> shamt_s;
      ALU_SRA:  y = $signed(a) >>> shamt_s;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// RV32 EX stage: forwarding muxes, ALU, multi-cycle multiplier, branch resolution
// and the EX/MEM pipeline register. XLEN must equal pipe_pkg::DATA_W.
module execute_stage
  import pipe_pkg::*;
#(
  parameter int XLEN    = DATA_W,
  parameter int MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallM,
  input  logic              FlushE,
  input  logic              ValidE,
  input  logic [XLEN-1:0]   RD1_E,
  input  logic [XLEN-1:0]   RD2_E,
  input  logic [XLEN-1:0]   ImmExt_E,
  input  logic [XLEN-1:0]   PC_E,
  input  logic [XLEN-1:0]   PCPlus4_E,
  input  logic [4:0]        RD_E,
  input  logic [3:0]        ALUControl_E,
  input  logic              ALUSrc_E,
  input  logic              RegWrite_E,
  input  logic              MemWrite_E,
  input  logic              Branch_E,
  input  logic              Jump_E,
  input  logic [1:0]        ResultSrc_E,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  input  logic [XLEN-1:0]   ALUResult_Mfwd,
  input  logic [XLEN-1:0]   Result_W,
  output logic [XLEN-1:0]   ALUResult_M,
  output logic [XLEN-1:0]   WriteData_M,
  output logic [XLEN-1:0]   PCPlus4_M,
  output logic [4:0]        RD_M,
  output logic              RegWrite_M,
  output logic              MemWrite_M,
  output logic [1:0]        ResultSrc_M,
  output logic              PCSrc_E,
  output logic [XLEN-1:0]   PCTarget_E,
  output logic              BusyE
);

  localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mul_state_t;

  alu_op_t          op_s;
  logic [XLEN-1:0]  srca_s;
  logic [XLEN-1:0]  fwd_b_s;
  logic [XLEN-1:0]  srcb_s;
  logic [XLEN-1:0]  alu_core_s;
  logic [XLEN-1:0]  mul_comb_s;
  logic [XLEN-1:0]  mul_latched_s;
  logic [XLEN-1:0]  alu_result_s;
  logic [XLEN-1:0]  capture_result_s;
  logic             is_mul_s;
  logic             zero_s;
  logic             mul_start_s;
  logic             busy_s;
  ex_mem_t          ex_mem_next_s;

  mul_state_t       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [XLEN-1:0]  mul_a_r;
  logic [XLEN-1:0]  mul_b_r;
  ex_mem_t          ex_mem_r;

  assign op_s = alu_op_t'(ALUControl_E);

  // Operand forwarding: code 11 falls back to the register file like 00.
  always_comb begin
    srca_s  = RD1_E;
    fwd_b_s = RD2_E;
    case (ForwardAE)
      FWD_WB:  srca_s = Result_W;
      FWD_MEM: srca_s = ALUResult_Mfwd;
      default: srca_s = RD1_E;
    endcase
    case (ForwardBE)
      FWD_WB:  fwd_b_s = Result_W;
      FWD_MEM: fwd_b_s = ALUResult_Mfwd;
      default: fwd_b_s = RD2_E;
    endcase
  end

  assign srcb_s = ALUSrc_E ? ImmExt_E : fwd_b_s;

  alu #(.XLEN(XLEN)) u_alu (
    .op (op_s),
    .a  (srca_s),
    .b  (srcb_s),
    .y  (alu_core_s)
  );

  assign is_mul_s      = (op_s == ALU_MUL);
  assign mul_comb_s    = srca_s * srcb_s;
  assign mul_latched_s = mul_a_r * mul_b_r;
  assign alu_result_s  = is_mul_s ? mul_comb_s : alu_core_s;
  // A multi-cycle product completes from the operands latched at start.
  assign capture_result_s = (state_r == BUSY) ? mul_latched_s : alu_result_s;

  assign zero_s     = (alu_result_s == {XLEN{1'b0}});
  assign PCSrc_E    = ValidE & ~FlushE & (Jump_E | (Branch_E & zero_s));
  assign PCTarget_E = PC_E + ImmExt_E;

  assign mul_start_s = ValidE & is_mul_s & ~FlushE & ~StallM & (MUL_LAT > 1);
  assign busy_s = ~rst & (((state_r == IDLE) & mul_start_s) |
                          ((state_r == BUSY) & (cnt_r != CNT_ZERO)));
  assign BusyE  = busy_s;

  // Multiplier sequencer: flush aborts, MEM stall freezes the countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      mul_a_r <= '0;
      mul_b_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (mul_start_s) begin
            state_r <= BUSY;
            cnt_r   <= CNT_LOAD;
            mul_a_r <= srca_s;
            mul_b_r <= srcb_s;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (FlushE) begin
            state_r <= IDLE;
          end else if (!StallM) begin
            if (cnt_r == CNT_ZERO) begin
              state_r <= IDLE;
            end else begin
              cnt_r <= cnt_r - CNT_W'(1);
            end
          end else begin
            state_r <= BUSY;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  always_comb begin
    ex_mem_next_s            = EX_MEM_BUBBLE;
    ex_mem_next_s.alu_result = capture_result_s;
    ex_mem_next_s.write_data = fwd_b_s;
    ex_mem_next_s.pc_plus4   = PCPlus4_E;
    ex_mem_next_s.rd         = RD_E;
    ex_mem_next_s.reg_write  = RegWrite_E;
    ex_mem_next_s.mem_write  = MemWrite_E;
    ex_mem_next_s.result_src = ResultSrc_E;
  end

  // EX/MEM register: stall holds, flush/busy/invalid inject a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_mem_r <= EX_MEM_BUBBLE;
    end else if (StallM) begin
      ex_mem_r <= ex_mem_r;
    end else if (FlushE | busy_s | ~ValidE) begin
      ex_mem_r <= EX_MEM_BUBBLE;
    end else begin
      ex_mem_r <= ex_mem_next_s;
    end
  end

  assign ALUResult_M = ex_mem_r.alu_result;
  assign WriteData_M = ex_mem_r.write_data;
  assign PCPlus4_M   = ex_mem_r.pc_plus4;
  assign RD_M        = ex_mem_r.rd;
  assign RegWrite_M  = ex_mem_r.reg_write;
  assign MemWrite_M  = ex_mem_r.mem_write;
  assign ResultSrc_M = ex_mem_r.result_src;

endmodule
